regfile_wb_arbiter: RTL

Write-port controller for the 32-entry register file. It shares the file's single write port between `NUM_REQ` writeback requesters (ALU pipeline, load unit, multicycle unit) using round-robin arbitration with a valid/ready handshake. It drives `RegWrite`/`RegWriteAddress`/`RegWriteData` from a registered output stage. It also keeps a busy scoreboard of destination registers with writes in flight, used by the decode stage for stall decisions.

---
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: round-robin arbitration among writeback
// requesters, a registered write stage, and a busy scoreboard for decode stalls.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_REQ       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]         iss_rd,
  output logic                             RegWrite,
  output logic [ADDRESS_WIDTH-1:0]         RegWriteAddress,
  output logic [DATA_WIDTH-1:0]            RegWriteData,
  output logic [NUM_REGS-1:0]              busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]         rrPtr;
  logic [PTR_W-1:0]         rrPtrNext;
  logic [PTR_W-1:0]         grantIdx;
  logic                     grantValid;
  logic [ADDRESS_WIDTH-1:0] reqAddrArr [NUM_REQ];
  logic [DATA_WIDTH-1:0]    reqDataArr [NUM_REQ];
  logic [ADDRESS_WIDTH-1:0] grantAddr;
  logic [DATA_WIDTH-1:0]    grantData;
  logic [NUM_REGS-1:0]      busyReg;
  logic [NUM_REGS-1:0]      busyNext;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
      assign reqAddrArr[gi] = req_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign reqDataArr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // First valid requester at or after rrPtr, with wrap; nothing is granted in reset.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!grantValid && req_valid[wrapAdd(rrPtr, off)]) begin
        grantValid = 1'b1;
        grantIdx   = wrapAdd(rrPtr, off);
      end
    end
    if (rst) grantValid = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (grantValid) req_ready[grantIdx] = 1'b1;
  end

  assign grantAddr = reqAddrArr[grantIdx];
  assign grantData = reqDataArr[grantIdx];
  assign rrPtrNext = wrapAdd(grantIdx, 1);

  // Output stage drains every cycle, so a grant is never back-pressured.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr           <= '0;
      RegWrite        <= 1'b0;
      RegWriteAddress <= '0;
      RegWriteData    <= '0;
    end else if (grantValid) begin
      rrPtr           <= rrPtrNext;
      RegWrite        <= (grantAddr != '0);
      RegWriteAddress <= grantAddr;
      RegWriteData    <= grantData;
    end else begin
      RegWrite        <= 1'b0;
    end
  end

  // Set beats clear: a re-issue of the same rd means a newer producer is pending.
  assign busyNext[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : gBusy
      assign busyNext[gi] = (iss_valid && iss_rd == ADDRESS_WIDTH'(gi)) ||
                            (busyReg[gi] && !(RegWrite && RegWriteAddress == ADDRESS_WIDTH'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) busyReg <= '0;
    else     busyReg <= busyNext;
  end

  assign busy = busyReg;

endmodule
